// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB, flush and execute-unit start/done signals of the ALU reservation station.
// The slave modport is the station's view; the master modport is the surrounding core's view.
interface alu_reservation_station_if #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = 4
);
  localparam int OCC_W = $clog2(NUM_ENTRIES) + 1;

  logic             flush;
  logic             dispatch_valid;
  logic             dispatch_ready;
  logic [4:0]       dispatch_aluop;
  logic [63:0]      dispatch_vala;
  logic [63:0]      dispatch_valb;
  logic             dispatch_vala_rdy;
  logic             dispatch_valb_rdy;
  logic [TAG_W-1:0] dispatch_vala_tag;
  logic [TAG_W-1:0] dispatch_valb_tag;
  logic [5:0]       dispatch_valhw;
  logic             dispatch_set_cc;
  logic [4:0]       dispatch_cond;
  logic [TAG_W-1:0] dispatch_dst_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [63:0]      cdb_value;
  logic             alu_start;
  logic [4:0]       alu_op;
  logic [63:0]      alu_vala;
  logic [63:0]      alu_valb;
  logic [5:0]       alu_valhw;
  logic             alu_set_cc;
  logic [4:0]       alu_cond;
  logic [TAG_W-1:0] alu_tag;
  logic             alu_done;
  logic [OCC_W-1:0] occupancy;

  modport slave (
    input  flush, dispatch_valid, dispatch_aluop, dispatch_vala, dispatch_valb,
           dispatch_vala_rdy, dispatch_valb_rdy, dispatch_vala_tag, dispatch_valb_tag,
           dispatch_valhw, dispatch_set_cc, dispatch_cond, dispatch_dst_tag,
           cdb_valid, cdb_tag, cdb_value, alu_done,
    output dispatch_ready, alu_start, alu_op, alu_vala, alu_valb, alu_valhw,
           alu_set_cc, alu_cond, alu_tag, occupancy
  );

  modport master (
    output flush, dispatch_valid, dispatch_aluop, dispatch_vala, dispatch_valb,
           dispatch_vala_rdy, dispatch_valb_rdy, dispatch_vala_tag, dispatch_valb_tag,
           dispatch_valhw, dispatch_set_cc, dispatch_cond, dispatch_dst_tag,
           cdb_valid, cdb_tag, cdb_value, alu_done,
    input  dispatch_ready, alu_start, alu_op, alu_vala, alu_valb, alu_valhw,
           alu_set_cc, alu_cond, alu_tag, occupancy
  );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds ops until operands wake from the CDB, issues oldest-ready with a start pulse
// two cycles after a ready dispatch, then waits for done; dispatch stalls when full or during flush.
module alu_reservation_station #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = 4
) (
  input logic clk,
  input logic rst,
  alu_reservation_station_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int OCC_W = IDX_W + 1;
  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] WAIT_DONE = 1'b1;

  logic [NUM_ENTRIES-1:0] ent_vld;
  logic [NUM_ENTRIES-1:0] ent_rdya;
  logic [NUM_ENTRIES-1:0] ent_rdyb;
  logic [NUM_ENTRIES-1:0] ent_set_cc;
  logic [4:0]             ent_op    [NUM_ENTRIES];
  logic [63:0]            ent_vala  [NUM_ENTRIES];
  logic [63:0]            ent_valb  [NUM_ENTRIES];
  logic [TAG_W-1:0]       ent_taga  [NUM_ENTRIES];
  logic [TAG_W-1:0]       ent_tagb  [NUM_ENTRIES];
  logic [5:0]             ent_valhw [NUM_ENTRIES];
  logic [4:0]             ent_cond  [NUM_ENTRIES];
  logic [TAG_W-1:0]       ent_dst   [NUM_ENTRIES];
  logic [IDX_W-1:0]       ent_age   [NUM_ENTRIES];

  logic [0:0]       state;
  logic [OCC_W-1:0] occ;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] sel_age;
  logic             sel_found;
  logic             accept;
  logic             issue;
  logic             d_rdya;
  logic             d_rdyb;
  logic [63:0]      d_vala;
  logic [63:0]      d_valb;

  assign bus.dispatch_ready = (occ < OCC_W'(NUM_ENTRIES)) && !bus.flush;
  assign bus.occupancy      = occ;
  assign accept             = bus.dispatch_valid && bus.dispatch_ready;
  assign issue              = (state == IDLE) && sel_found;

  // Operands not ready at dispatch may still be caught from this cycle's broadcast.
  assign d_rdya = bus.dispatch_vala_rdy || (bus.cdb_valid && bus.cdb_tag == bus.dispatch_vala_tag);
  assign d_rdyb = bus.dispatch_valb_rdy || (bus.cdb_valid && bus.cdb_tag == bus.dispatch_valb_tag);
  assign d_vala = bus.dispatch_vala_rdy ? bus.dispatch_vala : bus.cdb_value;
  assign d_valb = bus.dispatch_valb_rdy ? bus.dispatch_valb : bus.cdb_value;

  always_comb begin
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!ent_vld[i]) free_idx = IDX_W'(i);
    end
  end

  // Oldest ready entry wins; on an age tie the lowest index is kept.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (ent_vld[i] && ent_rdya[i] && ent_rdyb[i] && (!sel_found || ent_age[i] > sel_age)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = ent_age[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_vld  <= '0;
      ent_rdya <= '0;
      ent_rdyb <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (ent_vld[i] && !ent_rdya[i] && bus.cdb_valid && ent_taga[i] == bus.cdb_tag) begin
          ent_rdya[i] <= 1'b1;
          ent_vala[i] <= bus.cdb_value;
        end
        if (ent_vld[i] && !ent_rdyb[i] && bus.cdb_valid && ent_tagb[i] == bus.cdb_tag) begin
          ent_rdyb[i] <= 1'b1;
          ent_valb[i] <= bus.cdb_value;
        end
        if (accept && ent_vld[i] && ent_age[i] != {IDX_W{1'b1}}) ent_age[i] <= ent_age[i] + 1'b1;
      end
      if (issue) ent_vld[sel_idx] <= 1'b0;
      if (accept) begin
        ent_vld[free_idx]    <= 1'b1;
        ent_rdya[free_idx]   <= d_rdya;
        ent_rdyb[free_idx]   <= d_rdyb;
        ent_vala[free_idx]   <= d_vala;
        ent_valb[free_idx]   <= d_valb;
        ent_taga[free_idx]   <= bus.dispatch_vala_tag;
        ent_tagb[free_idx]   <= bus.dispatch_valb_tag;
        ent_op[free_idx]     <= bus.dispatch_aluop;
        ent_valhw[free_idx]  <= bus.dispatch_valhw;
        ent_set_cc[free_idx] <= bus.dispatch_set_cc;
        ent_cond[free_idx]   <= bus.dispatch_cond;
        ent_dst[free_idx]    <= bus.dispatch_dst_tag;
        ent_age[free_idx]    <= '0;
      end
      if (bus.flush) ent_vld <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      occ            <= '0;
      bus.alu_start  <= 1'b0;
      bus.alu_op     <= '0;
      bus.alu_vala   <= '0;
      bus.alu_valb   <= '0;
      bus.alu_valhw  <= '0;
      bus.alu_set_cc <= 1'b0;
      bus.alu_cond   <= '0;
      bus.alu_tag    <= '0;
    end else begin
      bus.alu_start <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            bus.alu_start  <= 1'b1;
            bus.alu_op     <= ent_op[sel_idx];
            bus.alu_vala   <= ent_vala[sel_idx];
            bus.alu_valb   <= ent_valb[sel_idx];
            bus.alu_valhw  <= ent_valhw[sel_idx];
            bus.alu_set_cc <= ent_set_cc[sel_idx];
            bus.alu_cond   <= ent_cond[sel_idx];
            bus.alu_tag    <= ent_dst[sel_idx];
            state          <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (bus.alu_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (bus.flush) occ <= '0;
      else if (accept && !issue) occ <= occ + 1'b1;
      else if (issue && !accept) occ <= occ - 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboarded bench for alu_reservation_station: expected issues are queued at dispatch and checked on alu_start.
module tb_alu_reservation_station;
  localparam int NUM_ENTRIES = 4;
  localparam int TAG_W       = 4;
  localparam logic [4:0] PLUS_OP = 5'd1;

  typedef struct packed {
    logic [4:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [5:0]  hw;
    logic        set_cc;
    logic [4:0]  cond;
    logic [3:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_reservation_station_if #(.NUM_ENTRIES(NUM_ENTRIES), .TAG_W(TAG_W)) bus ();
  alu_reservation_station #(.NUM_ENTRIES(NUM_ENTRIES), .TAG_W(TAG_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t sb[$];
  exp_t sb_head;
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   start_cnt = 0;
  int   start_cyc = 0;
  int   cyc       = 0;
  bit   inflight  = 1'b0;

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic exp_t mk_exp(input logic [4:0] op, input logic [3:0] dst,
                                  input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    e.op     = op;
    e.a      = a;
    e.b      = b;
    e.hw     = {2'b00, dst} + 6'd3;
    e.set_cc = dst[0];
    e.cond   = {dst, 1'b1};
    e.tag    = dst;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      inflight = 1'b0;
    end else begin
      if (bus.alu_start) begin
        start_cnt++;
        start_cyc = cyc;
        check_val("no_double_start", 64'(inflight), 64'd0);
        inflight = 1'b1;
        check_val("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          sb_head = sb.pop_front();
          check_val("issue_tag", 64'(bus.alu_tag), 64'(sb_head.tag));
          check_val("issue_vala", bus.alu_vala, sb_head.a);
          check_val("issue_valb", bus.alu_valb, sb_head.b);
          check_val("issue_ctl", 64'({bus.alu_op, bus.alu_valhw, bus.alu_set_cc, bus.alu_cond}),
                    64'({sb_head.op, sb_head.hw, sb_head.set_cc, sb_head.cond}));
        end
      end
      if (bus.alu_done) inflight = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input logic [4:0] op, input logic [3:0] dst,
                         input logic [63:0] a, input logic ar, input logic [3:0] at,
                         input logic [63:0] b, input logic br, input logic [3:0] bt);
    bus.dispatch_valid    = 1'b1;
    bus.dispatch_aluop    = op;
    bus.dispatch_dst_tag  = dst;
    bus.dispatch_vala     = a;
    bus.dispatch_vala_rdy = ar;
    bus.dispatch_vala_tag = at;
    bus.dispatch_valb     = b;
    bus.dispatch_valb_rdy = br;
    bus.dispatch_valb_tag = bt;
    bus.dispatch_valhw    = {2'b00, dst} + 6'd3;
    bus.dispatch_set_cc   = dst[0];
    bus.dispatch_cond     = {dst, 1'b1};
    step();
    bus.dispatch_valid = 1'b0;
  endtask

  task automatic cdb_bcast(input logic [3:0] tag, input logic [63:0] val);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_value = val;
    step();
    bus.cdb_valid = 1'b0;
  endtask

  task automatic done_pulse();
    bus.alu_done = 1'b1;
    step();
    bus.alu_done = 1'b0;
  endtask

  task automatic wait_start(input int prev, input string name);
    int n = 0;
    while (start_cnt == prev && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_val(name, 64'(start_cnt != prev), 64'd1);
  endtask

  int prev;
  int t0;

  initial begin
    bus.flush = 1'b0; bus.dispatch_valid = 1'b0; bus.dispatch_aluop = '0;
    bus.dispatch_vala = '0; bus.dispatch_valb = '0; bus.dispatch_vala_rdy = 1'b0;
    bus.dispatch_valb_rdy = 1'b0; bus.dispatch_vala_tag = '0; bus.dispatch_valb_tag = '0;
    bus.dispatch_valhw = '0; bus.dispatch_set_cc = 1'b0; bus.dispatch_cond = '0;
    bus.dispatch_dst_tag = '0; bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_value = '0;
    bus.alu_done = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_occ", 64'(bus.occupancy), 64'd0);
    check_val("rst_start", 64'(bus.alu_start), 64'd0);
    check_val("rst_ready", 64'(bus.dispatch_ready), 64'd1);
    check_val("rst_vala", bus.alu_vala, 64'd0);

    // Single ready ADD: start two cycles after dispatch.
    step();
    prev = start_cnt; t0 = cyc;
    sb.push_back(mk_exp(PLUS_OP, 4'd3, 64'd5, 64'd7));
    send_op(PLUS_OP, 4'd3, 64'd5, 1'b1, 4'd0, 64'd7, 1'b1, 4'd0);
    @(negedge clk);
    check_val("add_occ_t1", 64'(bus.occupancy), 64'd1);
    wait_start(prev, "add_start_seen");
    check_val("add_latency", 64'(start_cyc - t0), 64'd2);
    step();
    @(negedge clk);
    check_val("add_occ_t3", 64'(bus.occupancy), 64'd0);
    step();
    done_pulse();

    // Operand B waits for tag 9 on the CDB.
    prev = start_cnt; t0 = cyc;
    sb.push_back(mk_exp(5'd2, 4'd5, 64'h11, 64'h1234));
    send_op(5'd2, 4'd5, 64'h11, 1'b1, 4'd0, 64'hBAD, 1'b0, 4'd9);
    step();
    cdb_bcast(4'd9, 64'h1234);
    check_val("wake_no_early_start", 64'(start_cnt != prev || bus.alu_start), 64'd0);
    wait_start(prev, "wake_start_seen");
    check_val("wake_latency", 64'(start_cyc - t0), 64'd4);
    step();
    done_pulse();

    // Same-cycle bypass on operand A.
    prev = start_cnt; t0 = cyc;
    sb.push_back(mk_exp(5'd3, 4'd6, 64'hFF, 64'h22));
    bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd2; bus.cdb_value = 64'hFF;
    send_op(5'd3, 4'd6, 64'hDEAD, 1'b0, 4'd2, 64'h22, 1'b1, 4'd0);
    bus.cdb_valid = 1'b0;
    wait_start(prev, "bypass_start_seen");
    check_val("bypass_latency", 64'(start_cyc - t0), 64'd2);
    step();
    done_pulse();

    // Fill the station, all waiting on tag 8; issue must follow age order.
    prev = start_cnt;
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(mk_exp(5'd4, 4'(i), (i == 2) ? 64'h88 : 64'h100 + 64'(i), 64'h88));
      send_op(5'd4, 4'(i), 64'h100 + 64'(i), (i != 2), 4'd8, 64'hBAD, 1'b0, 4'd8);
    end
    @(negedge clk);
    check_val("full_occ", 64'(bus.occupancy), 64'd4);
    check_val("full_ready", 64'(bus.dispatch_ready), 64'd0);
    step();
    send_op(5'd5, 4'd15, 64'h1, 1'b1, 4'd0, 64'h2, 1'b1, 4'd0);
    check_val("full_no_start", 64'(start_cnt), 64'(prev));
    cdb_bcast(4'd8, 64'h88);
    for (int k = 0; k < 4; k++) begin
      wait_start(prev + k, "order_start_seen");
      step();
      repeat (3) step();
      check_val("order_hold_until_done", 64'(start_cnt), 64'(prev + k + 1));
      done_pulse();
    end

    // Flush with three waiting entries and one op in flight.
    prev = start_cnt;
    sb.push_back(mk_exp(5'd6, 4'd9, 64'h9, 64'h99));
    send_op(5'd6, 4'd9, 64'h9, 1'b1, 4'd0, 64'h99, 1'b1, 4'd0);
    wait_start(prev, "flush_start_seen");
    step();
    for (int i = 0; i < 3; i++) send_op(5'd7, 4'(10 + i), 64'h0, 1'b0, 4'd10, 64'h0, 1'b1, 4'd0);
    @(negedge clk);
    check_val("flush_pre_occ", 64'(bus.occupancy), 64'd3);
    step();
    bus.flush = 1'b1;
    bus.dispatch_valid = 1'b1; bus.dispatch_vala_rdy = 1'b1; bus.dispatch_valb_rdy = 1'b1;
    @(negedge clk);
    check_val("flush_ready", 64'(bus.dispatch_ready), 64'd0);
    step();
    bus.flush = 1'b0; bus.dispatch_valid = 1'b0;
    @(negedge clk);
    check_val("flush_occ", 64'(bus.occupancy), 64'd0);
    step();
    done_pulse();
    cdb_bcast(4'd10, 64'h77);
    repeat (6) step();
    check_val("flush_no_issue", 64'(start_cnt), 64'(prev + 1));

    // Reset while waiting for done with two entries held.
    prev = start_cnt;
    sb.push_back(mk_exp(5'd8, 4'd13, 64'h13, 64'h31));
    send_op(5'd8, 4'd13, 64'h13, 1'b1, 4'd0, 64'h31, 1'b1, 4'd0);
    wait_start(prev, "rst_start_seen");
    step();
    send_op(5'd9, 4'd14, 64'h0, 1'b0, 4'd11, 64'h0, 1'b1, 4'd0);
    send_op(5'd9, 4'd1, 64'h0, 1'b1, 4'd0, 64'h0, 1'b0, 4'd11);
    @(negedge clk);
    check_val("rst_pre_occ", 64'(bus.occupancy), 64'd2);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_val("rst2_occ", 64'(bus.occupancy), 64'd0);
    check_val("rst2_start", 64'(bus.alu_start), 64'd0);
    check_val("rst2_vala", bus.alu_vala, 64'd0);
    check_val("rst2_valb", bus.alu_valb, 64'd0);
    check_val("rst2_tag", 64'(bus.alu_tag), 64'd0);
    check_val("rst2_ctl", 64'({bus.alu_op, bus.alu_valhw, bus.alu_set_cc, bus.alu_cond}), 64'd0);
    check_val("rst2_ready", 64'(bus.dispatch_ready), 64'd1);
    step();
    done_pulse();
    cdb_bcast(4'd11, 64'h55);
    repeat (4) step();
    check_val("rst2_no_issue", 64'(start_cnt), 64'(prev + 1));

    prev = start_cnt; t0 = cyc;
    sb.push_back(mk_exp(PLUS_OP, 4'd2, 64'hA, 64'hB));
    send_op(PLUS_OP, 4'd2, 64'hA, 1'b1, 4'd0, 64'hB, 1'b1, 4'd0);
    wait_start(prev, "post_rst_start_seen");
    check_val("post_rst_latency", 64'(start_cyc - t0), 64'd2);
    step();
    done_pulse();
    repeat (2) step();
    check_val("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Issue side of the arithmetic execute unit's start/done handshake in the Tomasulo core.
- Holds decoded ALU operations from dispatch until both operands are valid, snooping the common data bus (CDB) for missing operands.
- Issues the oldest ready entry to the execute unit: pulses start, then waits for done.
- One op in flight at a time.

Parameters:
- NUM_ENTRIES, 4, number of station slots; power of two, ≥2.
- TAG_W, 4, width of producer/destination tags (ROB index).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  squash all held entries
- dispatch_valid  in  1  dispatch offers an op
- dispatch_ready  out  1  station accepts the op this cycle
- dispatch_aluop  in  5  alu_op_t encoding
- dispatch_vala / dispatch_valb  in  64 each  operand values, meaningful when the matching _rdy is high
- dispatch_vala_rdy / dispatch_valb_rdy  in  1 each  operand already valid
- dispatch_vala_tag / dispatch_valb_tag  in  TAG_W each  producer tag when the operand is not ready
- dispatch_valhw  in  6  shift amount
- dispatch_set_cc  in  1  op writes NZCV
- dispatch_cond  in  5  condition code
- dispatch_dst_tag  in  TAG_W  destination tag
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_value  in  64  broadcast value
- alu_start  out  1  one-cycle issue pulse
- alu_op  out  5  issued op
- alu_vala / alu_valb  out  64 each  issued operands
- alu_valhw  out  6  issued shift amount
- alu_set_cc  out  1  issued set-CC flag
- alu_cond  out  5  issued condition code
- alu_tag  out  TAG_W  issued destination tag
- alu_done  in  1  execute unit finished the in-flight op
- occupancy  out  log2(NUM_ENTRIES)+1  number of valid entries

Behaviour:
- Reset: synchronous on rst=1.
  - All entries invalid, FSM=IDLE.
  - alu_start=0; all alu_* data outputs=0; occupancy=0.
  - dispatch_ready=1 after reset deasserts.
- dispatch_ready = (occupancy < NUM_ENTRIES) && !flush. It is computed from the current occupancy, so a slot freed by an issue this cycle is not reusable until the next cycle.
- Allocation:
  - On dispatch_valid && dispatch_ready, write the lowest-index free slot; the entry becomes valid next cycle.
  - New entry age=0; every other valid entry's age increments, saturating at NUM_ENTRIES-1.
- Wakeup:
  - Each cycle, any valid entry operand with rdy=0 and tag==cdb_tag while cdb_valid=1 captures cdb_value and sets rdy=1.
  - Same-cycle bypass: if a dispatched operand is not ready and its tag matches a valid CDB broadcast that cycle, it is stored as ready with cdb_value.
  - Both operands may wake in the same cycle.
- Selection: combinational. Among valid entries with both operands ready, choose the highest age; ages are unique, so there are no ties.
- FSM:
  - IDLE:
    - If a ready entry exists: register its fields onto alu_*, alu_start=1 for exactly one cycle, invalidate the entry, go to WAIT_DONE.
    - Else alu_start=0.
  - WAIT_DONE:
    - alu_start=0; alu_* outputs hold their values.
    - On alu_done=1, go to IDLE. The next issue can occur no earlier than the cycle after done is seen, so the minimum issue spacing is 2 cycles from done.
  - alu_done seen in IDLE is ignored.
- Latency: dispatch with both operands ready at cycle t, station otherwise empty and IDLE → alu_start high in cycle t+2.
- Occupancy updates every cycle: +1 on accept, −1 on issue; simultaneous accept and issue leave it unchanged.
- flush:
  - Invalidates all entries next cycle and blocks dispatch that cycle.
  - Does not change FSM state. An in-flight op still completes via alu_done, and the FSM returns to IDLE normally.
  - A flush coinciding with an issue still produces the alu_start pulse.
- A CDB broadcast does not affect the in-flight op or any free slot.

Test Plan:
- Reset, then dispatch ADD (op=PLUS_OP, a=5 rdy, b=7 rdy, dst=3) at cycle t → alu_start=1 at t+2 with alu_vala=5, alu_valb=7, alu_tag=3; occupancy 1 at t+1 and 0 at t+3.
- Dispatch op with b not ready (tag=9), then cdb_valid with tag 9, value 0x1234 two cycles later → no alu_start before the CDB; alu_start 2 cycles after the broadcast with alu_valb=0x1234.
- Same-cycle bypass: dispatch with a not ready (tag=2) while cdb_valid, tag=2, value=0xFF → issued with alu_vala=0xFF.
- Fill 4 entries (dst 1..4, all waiting on tag 8), hold alu_done low → dispatch_ready=0, occupancy=4. Broadcast tag 8 → issue order by alu_tag is 1,2,3,4, each issue only after alu_done; alu_start never asserted twice without an intervening done.
- Flush with 3 waiting entries and 1 in flight → occupancy=0 next cycle; the pending alu_done returns the FSM to IDLE; no further alu_start.
- Assert rst while in WAIT_DONE with 2 entries → next cycle occupancy=0, alu_start=0, all alu_* outputs=0, dispatch_ready=1; a later alu_done is ignored.
